// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Two-port round-robin front end for a single-port 128x256 fragment SRAM
//   macro. One access per cycle; all macro pins come straight from flops.
//   Read data returns two cycles after the grant, tagged by a one-hot rvalid.
//   Optional build macro SRAM_ARB_INIT_EN adds a power-on sweep that zeroes
//   every word before any grant is issued.
module sram_port_arbiter #(
  parameter int DW = 256,
  parameter int AW = 7
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [1:0]    req_i,
  input  logic [1:0]    we_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [DW-1:0] wdata0_i,
  input  logic [DW-1:0] wdata1_i,
  input  logic [DW-1:0] wmask0_i,
  input  logic [DW-1:0] wmask1_i,
  output logic [1:0]    gnt_o,
  output logic [1:0]    rvalid_o,
  output logic [DW-1:0] rdata_o,
  output logic          init_done_o,
  input  logic [1:0]    cfg_rtsel_i,
  input  logic [1:0]    cfg_wtsel_i,
  output logic          mem_ceb_o,
  output logic          mem_web_o,
  output logic [AW-1:0] mem_a_o,
  output logic [DW-1:0] mem_d_o,
  output logic [DW-1:0] mem_bweb_o,
  output logic [1:0]    mem_rtsel_o,
  output logic [1:0]    mem_wtsel_o,
  input  logic [DW-1:0] mem_q_i
);

  // Round-robin pointer: 0 = port 0 preferred on a collision.
  logic          r_ptr;
  logic [1:0]    w_gnt;
  logic          w_sel;
  logic          w_acc;
  logic          w_grant_en;
  logic          w_init_done;
  logic [1:0]    w_rd_acc;
  logic [1:0]    r_rd_s1;
  logic [1:0]    r_rvalid;

  logic [AW-1:0] w_addr  [2];
  logic [DW-1:0] w_wdata [2];
  logic [DW-1:0] w_wmask [2];

  logic          r_ceb;
  logic          r_web;
  logic [AW-1:0] r_a;
  logic [DW-1:0] r_d;
  logic [DW-1:0] r_bweb;
  logic [1:0]    r_rtsel;
  logic [1:0]    r_wtsel;

  assign w_addr[0]  = addr0_i;
  assign w_addr[1]  = addr1_i;
  assign w_wdata[0] = wdata0_i;
  assign w_wdata[1] = wdata1_i;
  assign w_wmask[0] = wmask0_i;
  assign w_wmask[1] = wmask1_i;

`ifdef SRAM_ARB_INIT_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [AW-1:0] r_init_addr;
  logic [AW-1:0] w_init_addr_next;
  logic          w_init_active;

  // State and sweep-address register; reset always restarts the sweep at 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_INIT;
      r_init_addr <= '0;
    end else begin
      r_state     <= w_state_next;
      r_init_addr <= w_init_addr_next;
    end
  end

  // Sweep one word per cycle; the last word hands over to RUN without wrapping.
  always_comb begin
    w_state_next     = r_state;
    w_init_addr_next = r_init_addr;
    w_init_active    = 1'b0;
    w_init_done      = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_init_active = 1'b1;
        if (r_init_addr == {AW{1'b1}}) begin
          w_state_next = ST_RUN;
        end else begin
          w_init_addr_next = r_init_addr + {{(AW-1){1'b0}}, 1'b1};
        end
      end
      ST_RUN: begin
        w_init_done = 1'b1;
      end
      default: begin
        w_state_next = ST_INIT;
      end
    endcase
  end
`else
  assign w_init_done = 1'b1;
`endif

  assign w_grant_en = w_init_done & ~RST;

  // Combinational grant: a lone requester wins, a collision goes to r_ptr.
  always_comb begin
    w_gnt = 2'b00;
    w_sel = 1'b0;
    if (w_grant_en) begin
      case (req_i)
        2'b01: begin
          w_gnt = 2'b01;
          w_sel = 1'b0;
        end
        2'b10: begin
          w_gnt = 2'b10;
          w_sel = 1'b1;
        end
        2'b11: begin
          w_sel = r_ptr;
          w_gnt = r_ptr ? 2'b10 : 2'b01;
        end
        default: begin
          w_gnt = 2'b00;
          w_sel = 1'b0;
        end
      endcase
    end
  end

  assign w_acc = |(req_i & w_gnt);

  // Per-port accepted read, used to tag the return pipeline.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign w_rd_acc[gi] = req_i[gi] & w_gnt[gi] & ~we_i[gi];
  end

  // After any grant the other port becomes preferred; idle cycles hold.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ptr <= 1'b0;
    end else if (w_acc) begin
      r_ptr <= ~w_sel;
    end
  end

  // Macro pin registers: sweep write, accepted access, or idle (A/D hold).
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ceb  <= 1'b1;
      r_web  <= 1'b1;
      r_a    <= '0;
      r_d    <= '0;
      r_bweb <= '1;
    end
`ifdef SRAM_ARB_INIT_EN
    else if (w_init_active) begin
      r_ceb  <= 1'b0;
      r_web  <= 1'b0;
      r_a    <= r_init_addr;
      r_d    <= '0;
      r_bweb <= '0;
    end
`endif
    else if (w_acc) begin
      r_ceb  <= 1'b0;
      r_web  <= ~we_i[w_sel];
      r_a    <= w_addr[w_sel];
      r_d    <= w_wdata[w_sel];
      r_bweb <= ~w_wmask[w_sel];
    end else begin
      r_ceb  <= 1'b1;
      r_web  <= 1'b1;
      r_bweb <= '1;
    end
  end

  // Timing selects are plain one-cycle copies, running in every state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rtsel <= 2'b00;
      r_wtsel <= 2'b00;
    end else begin
      r_rtsel <= cfg_rtsel_i;
      r_wtsel <= cfg_wtsel_i;
    end
  end

  // Two-stage shift of the read grant id; matches the macro's registered Q.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rd_s1  <= 2'b00;
      r_rvalid <= 2'b00;
    end else begin
      r_rd_s1  <= w_rd_acc;
      r_rvalid <= r_rd_s1;
    end
  end

  assign gnt_o       = w_gnt;
  assign rvalid_o    = r_rvalid;
  assign rdata_o     = mem_q_i;
  assign init_done_o = w_init_done;
  assign mem_ceb_o   = r_ceb;
  assign mem_web_o   = r_web;
  assign mem_a_o     = r_a;
  assign mem_d_o     = r_d;
  assign mem_bweb_o  = r_bweb;
  assign mem_rtsel_o = r_rtsel;
  assign mem_wtsel_o = r_wtsel;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Testbench for sram_port_arbiter: behavioural macro, reference memory and
// expected-read queue; directed scenarios followed by a randomized run.
module tb_sram_port_arbiter;
  localparam int DW = 256;
  localparam int AW = 7;

  logic          CLK = 1'b0;
  logic          RST;
  logic [1:0]    req_i, we_i;
  logic [AW-1:0] addr0_i, addr1_i;
  logic [DW-1:0] wdata0_i, wdata1_i, wmask0_i, wmask1_i;
  logic [1:0]    gnt_o, rvalid_o;
  logic [DW-1:0] rdata_o;
  logic          init_done_o;
  logic [1:0]    cfg_rtsel_i, cfg_wtsel_i;
  logic          mem_ceb_o, mem_web_o;
  logic [AW-1:0] mem_a_o;
  logic [DW-1:0] mem_d_o, mem_bweb_o;
  logic [1:0]    mem_rtsel_o, mem_wtsel_o;
  logic [DW-1:0] mem_q_i;

  always #5 CLK = ~CLK;

  sram_port_arbiter #(.DW(DW), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .req_i(req_i), .we_i(we_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i),
    .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
    .wmask0_i(wmask0_i), .wmask1_i(wmask1_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .init_done_o(init_done_o),
    .cfg_rtsel_i(cfg_rtsel_i), .cfg_wtsel_i(cfg_wtsel_i),
    .mem_ceb_o(mem_ceb_o), .mem_web_o(mem_web_o), .mem_a_o(mem_a_o),
    .mem_d_o(mem_d_o), .mem_bweb_o(mem_bweb_o),
    .mem_rtsel_o(mem_rtsel_o), .mem_wtsel_o(mem_wtsel_o),
    .mem_q_i(mem_q_i)
  );

  // Behavioural single-port macro: registered Q, active-low CEB/WEB/BWEB.
  logic [DW-1:0] sram [128];
  always @(posedge CLK) begin
    if (mem_ceb_o === 1'b0) begin
      if (mem_web_o === 1'b0)
        sram[mem_a_o] <= (sram[mem_a_o] & mem_bweb_o) | (mem_d_o & ~mem_bweb_o);
      else
        mem_q_i <= sram[mem_a_o];
    end
  end

  // Reference model state
  typedef struct {
    int            due;
    bit            port;
    logic [DW-1:0] data;
  } rd_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  bit            m_ptr = 1'b0;
  logic [DW-1:0] m_mem [128];
  rd_t           rd_q [$];
  logic          m_ceb = 1'b1, m_web = 1'b1;
  logic [AW-1:0] m_a = '0;
  logic [DW-1:0] m_d = '0, m_bweb = '1;
  logic [1:0]    m_rtsel = 2'b00, m_wtsel = 2'b00;
  int            m_init_cnt = 0;

  logic [1:0]    obs_gnt, obs_rvalid, obs_rtsel, obs_wtsel;
  logic [DW-1:0] obs_rdata, obs_d, obs_bweb;
  logic          obs_done, obs_ceb, obs_web;
  logic [AW-1:0] obs_a;
  logic [1:0]    exp_gnt, exp_rvalid, exp_rtsel, exp_wtsel;
  logic [DW-1:0] exp_rdata, exp_d, exp_bweb;
  logic          exp_done, exp_ceb, exp_web;
  logic [AW-1:0] exp_a;

  function automatic logic [DW-1:0] rand256();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic bit model_ready();
`ifdef SRAM_ARB_INIT_EN
    return (m_init_cnt >= 128);
`else
    return 1'b1;
`endif
  endfunction

  // One clock cycle: sample DUT at negedge, derive expectations from the
  // model, advance the model, then return 1 time unit after the next posedge.
  task automatic tick();
    int            w;
    logic [AW-1:0] ad;
    logic [DW-1:0] dt, mk;
    @(negedge CLK);
    obs_gnt = gnt_o;   obs_rvalid = rvalid_o; obs_rdata = rdata_o;
    obs_done = init_done_o;
    obs_ceb = mem_ceb_o; obs_web = mem_web_o; obs_a = mem_a_o;
    obs_d = mem_d_o;   obs_bweb = mem_bweb_o;
    obs_rtsel = mem_rtsel_o; obs_wtsel = mem_wtsel_o;
    exp_ceb = m_ceb; exp_web = m_web; exp_a = m_a; exp_d = m_d; exp_bweb = m_bweb;
    exp_rtsel = m_rtsel; exp_wtsel = m_wtsel;
    exp_rvalid = 2'b00; exp_rdata = '0;
    if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      exp_rvalid = rd_q[0].port ? 2'b10 : 2'b01;
      exp_rdata  = rd_q[0].data;
      void'(rd_q.pop_front());
    end
    exp_done = model_ready();
    exp_gnt  = 2'b00;
    if (RST) begin
      rd_q.delete();
      m_ptr = 1'b0;
      m_ceb = 1'b1; m_web = 1'b1; m_a = '0; m_d = '0; m_bweb = '1;
      m_rtsel = 2'b00; m_wtsel = 2'b00;
      m_init_cnt = 0;
    end else begin
      m_rtsel = cfg_rtsel_i;
      m_wtsel = cfg_wtsel_i;
`ifdef SRAM_ARB_INIT_EN
      if (m_init_cnt < 128) begin
        m_mem[m_init_cnt] = '0;
        m_ceb = 1'b0; m_web = 1'b0; m_a = AW'(m_init_cnt); m_d = '0; m_bweb = '0;
        m_init_cnt++;
      end else
`endif
      if (req_i != 2'b00) begin
        w = (req_i == 2'b11) ? int'(m_ptr) : (req_i[1] ? 1 : 0);
        exp_gnt = (w == 1) ? 2'b10 : 2'b01;
        m_ptr = (w == 0);
        ad = (w == 1) ? addr1_i : addr0_i;
        dt = (w == 1) ? wdata1_i : wdata0_i;
        mk = (w == 1) ? wmask1_i : wmask0_i;
        if (we_i[w]) m_mem[ad] = (m_mem[ad] & ~mk) | (dt & mk);
        else rd_q.push_back('{due: cyc + 2, port: (w == 1), data: m_mem[ad]});
        m_ceb = 1'b0; m_web = ~we_i[w]; m_a = ad; m_d = dt; m_bweb = ~mk;
        $display("ACC cyc=%0d port=%0d %s addr=%0d", cyc, w, we_i[w] ? "WR" : "RD", ad);
      end else begin
        m_ceb = 1'b1; m_web = 1'b1; m_bweb = '1;
      end
    end
    cyc++;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_port(int p, bit we, logic [AW-1:0] a, logic [DW-1:0] d, logic [DW-1:0] m);
    we_i[p] = we;
    if (p == 0) begin addr0_i = a; wdata0_i = d; wmask0_i = m; end
    else begin addr1_i = a; wdata1_i = d; wmask1_i = m; end
  endtask

  // Single-port access lasting exactly one cycle.
  task automatic do_acc(int p, bit we, logic [AW-1:0] a, logic [DW-1:0] d, logic [DW-1:0] m);
    set_port(p, we, a, d, m);
    req_i = (p == 1) ? 2'b10 : 2'b01;
    tick();
    req_i = 2'b00;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 300 && !model_ready(); i++) tick();
  endtask

  task automatic test_reset();
    RST = 1'b1; req_i = 2'b11; we_i = 2'b00;
    cfg_rtsel_i = 2'b11; cfg_wtsel_i = 2'b10;
    tick();
    tick();
    checks++; if (obs_ceb !== 1'b1) begin errors++; $display("FAIL reset_ceb got=%b exp=1", obs_ceb); end
    checks++; if (obs_web !== 1'b1) begin errors++; $display("FAIL reset_web got=%b exp=1", obs_web); end
    checks++; if (obs_bweb !== {DW{1'b1}}) begin errors++; $display("FAIL reset_bweb got=%h exp=all1", obs_bweb); end
    checks++; if (obs_a !== '0 || obs_d !== '0) begin errors++; $display("FAIL reset_a_d got a=%0d d=%h exp=0", obs_a, obs_d); end
    checks++; if (obs_rvalid !== 2'b00) begin errors++; $display("FAIL reset_rvalid got=%b exp=00", obs_rvalid); end
    checks++; if (obs_gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b exp=00", obs_gnt); end
    checks++; if (obs_rtsel !== 2'b00 || obs_wtsel !== 2'b00) begin errors++; $display("FAIL reset_tsel got=%b/%b exp=00/00", obs_rtsel, obs_wtsel); end
    RST = 1'b0; req_i = 2'b00;
    tick();
    checks++; if (obs_done !== exp_done) begin errors++; $display("FAIL reset_init_done got=%b exp=%b", obs_done, exp_done); end
    tick();
    checks++; if (obs_rtsel !== 2'b11 || obs_wtsel !== 2'b10) begin errors++; $display("FAIL tsel_copy got=%b/%b exp=11/10", obs_rtsel, obs_wtsel); end
    wait_ready();
  endtask

`ifdef SRAM_ARB_INIT_EN
  task automatic test_init();
    int n;
    RST = 1'b1; req_i = 2'b11; we_i = 2'b00;
    set_port(0, 1'b0, 7'd0, '0, '1);
    set_port(1, 1'b0, 7'd0, '0, '1);
    tick();
    tick();
    RST = 1'b0;
    n = 0;
    for (int i = 1; i <= 300 && n == 0; i++) begin
      tick();
      if (i == 2) begin
        checks++;
        if (obs_ceb !== 1'b0 || obs_web !== 1'b0 || obs_bweb !== '0 || obs_a !== '0 || obs_d !== '0) begin
          errors++; $display("FAIL init_first_word got ceb=%b web=%b a=%0d exp ceb=0 web=0 a=0 bweb=0 d=0", obs_ceb, obs_web, obs_a);
        end
      end
      if (obs_done === 1'b1) n = i;
      else begin
        checks++; if (obs_gnt !== 2'b00) begin errors++; $display("FAIL init_gnt cycle=%0d got=%b exp=00", i, obs_gnt); end
      end
    end
    checks++; if (n != 129) begin errors++; $display("FAIL init_done_cycle got=%0d exp=129", n); end
    checks++; if (obs_gnt !== 2'b01) begin errors++; $display("FAIL init_first_gnt got=%b exp=01", obs_gnt); end
    req_i = 2'b00;
    do_acc(1, 1'b0, 7'd127, '0, '1);
    tick();
    tick();
    checks++; if (obs_rvalid !== 2'b10 || obs_rdata !== '0) begin errors++; $display("FAIL init_read127 got rv=%b d=%h exp rv=10 d=0", obs_rvalid, obs_rdata); end
  endtask
`endif

  task automatic test_write_read();
    logic [DW-1:0] pat;
    pat = {32{8'hA5}};
    do_acc(0, 1'b1, 7'd5, pat, '1);
    checks++; if (obs_gnt !== 2'b01) begin errors++; $display("FAIL wr_gnt got=%b exp=01", obs_gnt); end
    do_acc(1, 1'b0, 7'd5, '0, '0);
    checks++; if (obs_gnt !== 2'b10) begin errors++; $display("FAIL rd_gnt got=%b exp=10", obs_gnt); end
    checks++;
    if (obs_ceb !== 1'b0 || obs_web !== 1'b0 || obs_a !== 7'd5 || obs_d !== pat || obs_bweb !== '0) begin
      errors++; $display("FAIL wr_pins got ceb=%b web=%b a=%0d exp ceb=0 web=0 a=5", obs_ceb, obs_web, obs_a);
    end
    tick();
    checks++; if (obs_ceb !== 1'b0 || obs_web !== 1'b1 || obs_a !== 7'd5) begin errors++; $display("FAIL rd_pins got ceb=%b web=%b a=%0d exp ceb=0 web=1 a=5", obs_ceb, obs_web, obs_a); end
    checks++; if (obs_rvalid !== 2'b00) begin errors++; $display("FAIL rd_early got=%b exp=00", obs_rvalid); end
    tick();
    checks++; if (obs_rvalid !== 2'b10) begin errors++; $display("FAIL rd_rvalid got=%b exp=10", obs_rvalid); end
    checks++; if (obs_rdata !== pat) begin errors++; $display("FAIL rd_data got=%h exp=%h", obs_rdata, pat); end
    checks++; if (obs_ceb !== 1'b1 || obs_web !== 1'b1 || obs_bweb !== {DW{1'b1}} || obs_a !== 7'd5) begin errors++; $display("FAIL idle_pins got ceb=%b web=%b a=%0d exp ceb=1 web=1 a=5 bweb=all1", obs_ceb, obs_web, obs_a); end
  endtask

  task automatic test_alternation();
    logic [1:0] expg;
    set_port(0, 1'b0, 7'd1, '0, '0);
    set_port(1, 1'b0, 7'd2, '0, '0);
    req_i = 2'b11;
    for (int i = 0; i < 6; i++) begin
      tick();
      expg = (i % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (obs_gnt !== expg) begin errors++; $display("FAIL alt_gnt i=%0d got=%b exp=%b", i, obs_gnt, expg); end
    end
    req_i = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (obs_rvalid !== exp_rvalid) begin errors++; $display("FAIL alt_rvalid i=%0d got=%b exp=%b", i, obs_rvalid, exp_rvalid); end
    end
  endtask

  task automatic test_partial_write();
    logic [DW-1:0] m;
    m = '0; m[7:0] = 8'hFF;
    do_acc(1, 1'b1, 7'd9, '0, '1);
    do_acc(1, 1'b1, 7'd9, '1, m);
    do_acc(0, 1'b1, 7'd9, '1, '0);
    checks++; if (obs_gnt !== 2'b01) begin errors++; $display("FAIL zero_mask_gnt got=%b exp=01", obs_gnt); end
    do_acc(0, 1'b0, 7'd9, '0, '0);
    tick();
    tick();
    checks++; if (obs_rvalid !== 2'b01) begin errors++; $display("FAIL partial_rvalid got=%b exp=01", obs_rvalid); end
    checks++; if (obs_rdata !== m) begin errors++; $display("FAIL partial_data got=%h exp=%h", obs_rdata, m); end
  endtask

  task automatic test_reset_mid();
    do_acc(0, 1'b0, 7'd9, '0, '0);
    RST = 1'b1;
    tick();
    checks++; if (obs_rvalid !== 2'b00) begin errors++; $display("FAIL rstmid_rv1 got=%b exp=00", obs_rvalid); end
    RST = 1'b0;
    tick();
    checks++; if (obs_rvalid !== 2'b00) begin errors++; $display("FAIL rstmid_rv2 got=%b exp=00", obs_rvalid); end
    tick();
    checks++; if (obs_rvalid !== 2'b00) begin errors++; $display("FAIL rstmid_rv3 got=%b exp=00", obs_rvalid); end
    wait_ready();
    set_port(0, 1'b0, 7'd9, '0, '0);
    set_port(1, 1'b0, 7'd9, '0, '0);
    req_i = 2'b11;
    tick();
    checks++; if (obs_gnt !== 2'b01) begin errors++; $display("FAIL rstmid_ptr got=%b exp=01", obs_gnt); end
    req_i = 2'b00;
    tick();
    tick();
    checks++; if (obs_rvalid !== 2'b01) begin errors++; $display("FAIL rstmid_rvalid got=%b exp=01", obs_rvalid); end
    checks++; if (obs_rdata !== exp_rdata) begin errors++; $display("FAIL rstmid_data got=%h exp=%h", obs_rdata, exp_rdata); end
  endtask

  task automatic test_random();
    bit            pend [2];
    logic [DW-1:0] mk;
    int            sel;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int c = 0; c < 800; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 99) < 55) begin
          pend[p] = 1'b1;
          sel = $urandom_range(0, 7);
          mk = (sel == 0) ? '0 : (sel < 3) ? '1 : rand256();
          set_port(p, 1'($urandom_range(0, 1)),
                   AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 7)),
                   rand256(), mk);
        end
      end
      req_i = {pend[1], pend[0]};
      cfg_rtsel_i = 2'($urandom_range(0, 3));
      cfg_wtsel_i = 2'($urandom_range(0, 3));
      RST = ($urandom_range(0, 299) == 0);
      tick();
      checks++; if (obs_gnt !== exp_gnt) begin errors++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, obs_gnt, exp_gnt); end
      checks++; if (obs_rvalid !== exp_rvalid) begin errors++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", cyc, obs_rvalid, exp_rvalid); end
      if (exp_rvalid != 2'b00) begin
        checks++; if (obs_rdata !== exp_rdata) begin errors++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, obs_rdata, exp_rdata); end
      end
      checks++; if (obs_ceb !== exp_ceb || obs_web !== exp_web || obs_a !== exp_a || obs_bweb !== exp_bweb || obs_d !== exp_d) begin
        errors++; $display("FAIL rnd_pins cyc=%0d got ceb=%b web=%b a=%0d exp ceb=%b web=%b a=%0d", cyc, obs_ceb, obs_web, obs_a, exp_ceb, exp_web, exp_a);
      end
      checks++; if (obs_rtsel !== exp_rtsel || obs_wtsel !== exp_wtsel) begin errors++; $display("FAIL rnd_tsel cyc=%0d got=%b/%b exp=%b/%b", cyc, obs_rtsel, obs_wtsel, exp_rtsel, exp_wtsel); end
      checks++; if (obs_done !== exp_done) begin errors++; $display("FAIL rnd_done cyc=%0d got=%b exp=%b", cyc, obs_done, exp_done); end
      for (int p = 0; p < 2; p++) if (exp_gnt[p]) pend[p] = 1'b0;
    end
    RST = 1'b0;
    req_i = 2'b00;
    for (int i = 0; i < 3; i++) tick();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin sram[i] = '0; m_mem[i] = '0; end
    mem_q_i = '0;
    RST = 1'b1; req_i = 2'b00; we_i = 2'b00;
    addr0_i = '0; addr1_i = '0; wdata0_i = '0; wdata1_i = '0; wmask0_i = '0; wmask1_i = '0;
    cfg_rtsel_i = 2'b00; cfg_wtsel_i = 2'b00;
    @(posedge CLK);
    #1;
    test_reset();
`ifdef SRAM_ARB_INIT_EN
    test_init();
`endif
    test_write_read();
    test_alternation();
    test_partial_write();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
